// File: rtl/seq_gen_multi.sv
// Multi-mode sequence generator: Johnson, one-hot ring, Fibonacci LFSR and Gray up/down counter.
// Optional wrap counter output period_cnt is built when SEQ_GEN_PERIOD_CNT_EN is defined.
module seq_gen_multi #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap
`ifdef SEQ_GEN_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'd0,
        MODE_RING    = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_GRAY    = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    mode_e            cur_mode;
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_bin_next;
    logic [WIDTH-2:0] johnson_trans;
    logic             ring_onehot;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] adv_out;
    logic             recover;
    logic             adv_wrap;

    assign cur_mode      = mode_e'(mode);
    // A legal Johnson state has at most one place where neighbouring bits differ.
    assign johnson_trans = out[WIDTH-2:0] ^ out[WIDTH-1:1];
    assign ring_onehot   = (out != ZERO) && ((out & (out - ONE)) == ZERO);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        gray_bin = '0;
        gray_bin[WIDTH-1] = out[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            gray_bin[i] = gray_bin[i+1] ^ out[i];
        end
    end

    assign gray_bin_next = dir ? (gray_bin - ONE) : (gray_bin + ONE);

    always_comb begin
        seed    = ZERO;
        adv_out = out;
        recover = 1'b0;
        case (cur_mode)
            MODE_JOHNSON: begin
                seed = ZERO;
                if ($countones(johnson_trans) > 1) begin
                    recover = 1'b1;
                    adv_out = seed;
                end else if (dir) begin
                    adv_out = {~out[0], out[WIDTH-1:1]};
                end else begin
                    adv_out = {out[WIDTH-2:0], ~out[WIDTH-1]};
                end
            end
            MODE_RING: begin
                seed = ONE;
                if (!ring_onehot) begin
                    recover = 1'b1;
                    adv_out = seed;
                end else if (dir) begin
                    adv_out = {out[0], out[WIDTH-1:1]};
                end else begin
                    adv_out = {out[WIDTH-2:0], out[WIDTH-1]};
                end
            end
            MODE_LFSR: begin
                seed = ONE;
                if (out == ZERO) begin
                    recover = 1'b1;
                    adv_out = seed;
                end else begin
                    adv_out = {out[WIDTH-2:0], ^(out & TAPS)};
                end
            end
            MODE_GRAY: begin
                seed    = ZERO;
                adv_out = gray_bin_next ^ (gray_bin_next >> 1);
            end
            default: begin
                seed    = ZERO;
                adv_out = out;
            end
        endcase
    end

    assign adv_wrap = !recover && (adv_out == seed);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            out  <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            out  <= adv_out;
            wrap <= adv_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef SEQ_GEN_PERIOD_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (load) begin
            period_cnt <= '0;
        end else if (en && adv_wrap && (period_cnt != 16'hFFFF)) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule
